// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR numbers, decode helpers and counter-slot mapping for the
// performance-counter CSR bank.
package csr_counter_unit_pkg;

    typedef enum logic [11:0] {
        MCOUNTINHIBIT = 12'h320,
        MCYCLE        = 12'hB00,
        MINSTRET      = 12'hB02,
        MHPMCOUNTER3  = 12'hB03,
        MCYCLEH       = 12'hB80,
        MINSTRETH     = 12'hB82,
        MHPMCOUNTER3H = 12'hB83,
        CYCLE         = 12'hC00,
        TIME          = 12'hC01,
        INSTRET       = 12'hC02,
        HPMCOUNTER3   = 12'hC03,
        CYCLEH        = 12'hC80,
        TIMEH         = 12'hC81,
        INSTRETH      = 12'hC82,
        HPMCOUNTER3H  = 12'hC83
    } csr_reg_t;

    localparam logic [3:0] GRP_M      = 4'hB;
    localparam logic [3:0] GRP_U      = 4'hC;
    localparam logic [7:0] HPM_OFS_LO = 8'h03;
    localparam logic [7:0] HPM_OFS_HI = 8'h83;

    typedef struct packed {
        logic       ctr;
        logic       ro;
        logic       hi;
        logic [4:0] idx;
    } csr_dec_t;

    function automatic csr_dec_t csr_decode(input logic [11:0] addr);
        csr_dec_t d;
        d.ro  = (addr[11:8] == GRP_U);
        d.ctr = (d.ro || (addr[11:8] == GRP_M)) && (addr[6:5] == 2'b00);
        d.hi  = addr[7];
        d.idx = addr[4:0];
        return d;
    endfunction

    // Counter slot 0 = cycle, 1 = instret, 2.. = hpm; returns its CSR low index.
    function automatic int unsigned cnt_csr_idx(input int unsigned slot);
        return (slot == 32'd0) ? 32'd0 : slot + 32'd1;
    endfunction

endpackage

// File: rtl/csr_counter_unit_if.sv
// Read/write CSR port plus retire/event pulses between the pipeline and the counter bank.
interface csr_counter_unit_if #(
    parameter int unsigned NUM_HPM = 4
);
    localparam int unsigned HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

    logic [11:0]      rd_addr;
    logic [31:0]      rd_data;
    logic             rd_hit;
    logic             we;
    logic [11:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             wr_illegal;
    logic             instr_retire;
    logic [HPM_W-1:0] hpm_event;

    modport master (
        output rd_addr, we, wr_addr, wr_data, instr_retire, hpm_event,
        input  rd_data, rd_hit, wr_illegal
    );

    modport slave (
        input  rd_addr, we, wr_addr, wr_data, instr_retire, hpm_event,
        output rd_data, rd_hit, wr_illegal
    );
endinterface

// File: rtl/csr_counter.sv
// One W-bit counter with per-half load; a load in either half suppresses the increment.
module csr_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_en_i,
    input  logic         wr_lo_i,
    input  logic         wr_hi_i,
    input  logic [31:0]  wr_data_i,
    output logic [W-1:0] value_o
);
    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (wr_lo_i) begin
            value_d[31:0] = wr_data_i;
        end else if (wr_hi_i) begin
            value_d[W-1:32] = wr_data_i[W-33:0];
        end else if (inc_en_i) begin
            value_d = value_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
endmodule

// File: rtl/csr_counter_unit.sv
// Performance-counter CSR bank: cycle/instret/hpm counters, prescaled time,
// mcountinhibit, combinational read port and write port.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter int unsigned NUM_HPM       = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned TIME_DIV      = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    csr_counter_unit_if.slave csr_bus
);
    localparam int unsigned W       = COUNTER_WIDTH;
    localparam int unsigned NUM_CNT = 2 + NUM_HPM;
    localparam int unsigned PW      = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] INH_MASK = 32'((64'd1 << (3 + NUM_HPM)) - 64'd1) & ~32'h2;

    logic [W-1:0]  cnt [NUM_CNT];
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  time_q, time_d;
    logic [31:0]   inh_q, inh_d;
    logic          tick;
    csr_dec_t      rd_dec, wr_dec;
    logic          rd_mapped, wr_inh, wr_ctr;
    logic [63:0]   rd_val;

    // Index 1 is time (read-only view only); hpm indices are bounded by NUM_HPM.
    function automatic logic idx_ok(input csr_dec_t d);
        logic [7:0] ofs;
        logic [7:0] lo8;
        ofs = d.hi ? HPM_OFS_HI : HPM_OFS_LO;
        lo8 = {d.hi, 2'b00, d.idx};
        return (d.idx == 5'd0) || (d.idx == 5'd2) || ((d.idx == 5'd1) && d.ro) ||
               ((lo8 >= ofs) && (32'(lo8) < 32'(ofs) + NUM_HPM));
    endfunction

    assign rd_dec    = csr_decode(csr_bus.rd_addr);
    assign wr_dec    = csr_decode(csr_bus.wr_addr);
    assign rd_mapped = rd_dec.ctr && idx_ok(rd_dec);
    assign wr_inh    = csr_bus.we && (csr_bus.wr_addr == 12'(MCOUNTINHIBIT));
    assign wr_ctr    = csr_bus.we && wr_dec.ctr && !wr_dec.ro && idx_ok(wr_dec);
    assign csr_bus.wr_illegal = csr_bus.we && !wr_inh && !wr_ctr;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        logic inc_en;
        logic wr_sel;
        assign wr_sel = wr_ctr && (32'(wr_dec.idx) == cnt_csr_idx(g));
        if (g == 0) begin : g_cycle
            assign inc_en = !inh_q[0];
        end else if (g == 1) begin : g_instret
            assign inc_en = csr_bus.instr_retire && !inh_q[2];
        end else begin : g_hpm
            assign inc_en = csr_bus.hpm_event[g-2] && !inh_q[g+1];
        end
        csr_counter #(.W(W)) u_cnt (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .inc_en_i  (inc_en),
            .wr_lo_i   (wr_sel && !wr_dec.hi),
            .wr_hi_i   (wr_sel && wr_dec.hi),
            .wr_data_i (csr_bus.wr_data),
            .value_o   (cnt[g])
        );
    end

    // Time prescaler and inhibit next-state.
    always_comb begin
        tick    = (presc_q == PW'(TIME_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        time_d  = tick ? time_q + W'(1) : time_q;
        inh_d   = wr_inh ? (csr_bus.wr_data & INH_MASK) : inh_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
            time_q  <= '0;
            inh_q   <= '0;
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
            inh_q   <= inh_d;
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_mapped && (rd_dec.idx == 5'd1)) begin
            rd_val = 64'(time_q);
        end else if (rd_mapped) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (32'(rd_dec.idx) == cnt_csr_idx(i)) rd_val = 64'(cnt[i]);
            end
        end
    end

    always_comb begin
        csr_bus.rd_data = '0;
        csr_bus.rd_hit  = 1'b0;
        if (csr_bus.rd_addr == 12'(MCOUNTINHIBIT)) begin
            csr_bus.rd_data = inh_q;
            csr_bus.rd_hit  = 1'b1;
        end else if (rd_mapped) begin
            csr_bus.rd_data = rd_dec.hi ? rd_val[63:32] : rd_val[31:0];
            csr_bus.rd_hit  = 1'b1;
        end
    end
endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: directed scenarios plus random traffic against a behavioural model.
module tb_csr_counter_unit;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    csr_counter_unit_if #(.NUM_HPM(4)) bus_a ();
    csr_counter_unit_if #(.NUM_HPM(2)) bus_b ();

    csr_counter_unit #(.NUM_HPM(4), .COUNTER_WIDTH(64), .TIME_DIV(4)) dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .csr_bus (bus_a)
    );

    csr_counter_unit #(.NUM_HPM(2), .COUNTER_WIDTH(40), .TIME_DIV(1)) dut_b (
        .clk_i   (clk),
        .reset_i (rst_b),
        .csr_bus (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model of dut_a: slot 0 cycle, 1 instret, 2..5 hpm3..hpm6.
    localparam logic [31:0] INH_MASK_A = 32'h0000_007D;
    longint unsigned m_cnt [6];
    longint unsigned m_time;
    int              m_presc;
    logic [31:0]     m_inh;
    logic            last_ill;

    logic [11:0] pool [24] = '{
        12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06, 12'hB86,
        12'hB07, 12'hB01, 12'h320, 12'h321, 12'hC00, 12'hC80, 12'hC01, 12'hC81,
        12'hC02, 12'hC82, 12'hC03, 12'hC83, 12'hC06, 12'hC86, 12'hC07, 12'hB81
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int csr_num(input int c);
        return (c == 0) ? 0 : c + 1;
    endfunction

    function automatic void model_reset();
        foreach (m_cnt[c]) m_cnt[c] = 0;
        m_time  = 0;
        m_presc = 0;
        m_inh   = '0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output logic h);
        longint unsigned v;
        d = '0;
        h = 1'b0;
        v = 0;
        if (a == 12'h320) begin
            d = m_inh;
            h = 1'b1;
        end else if (a == 12'hC01 || a == 12'hC81) begin
            v = m_time;
            h = 1'b1;
            d = (a == 12'hC81) ? v[63:32] : v[31:0];
        end else begin
            for (int c = 0; c < 6; c++) begin
                v = m_cnt[c];
                if (a == 12'hB00 + 12'(csr_num(c)) || a == 12'hC00 + 12'(csr_num(c))) begin
                    d = v[31:0];
                    h = 1'b1;
                end
                if (a == 12'hB80 + 12'(csr_num(c)) || a == 12'hC80 + 12'(csr_num(c))) begin
                    d = v[63:32];
                    h = 1'b1;
                end
            end
        end
    endfunction

    function automatic bit wr_target(input logic [11:0] a, output int wc, output bit whi);
        wc  = -1;
        whi = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (a == 12'hB00 + 12'(csr_num(c))) wc = c;
            if (a == 12'hB80 + 12'(csr_num(c))) begin
                wc  = c;
                whi = 1'b1;
            end
        end
        return (wc >= 0) || (a == 12'h320);
    endfunction

    function automatic void model_step(input bit we, input logic [11:0] wa, input logic [31:0] wd,
                                       input bit ret, input logic [3:0] hpm);
        int          wc;
        bit          whi;
        bit          inc;
        logic [31:0] inh_next;
        inh_next = m_inh;
        wc  = -1;
        whi = 1'b0;
        if (we) begin
            if (wa == 12'h320) inh_next = wd & INH_MASK_A;
            else void'(wr_target(wa, wc, whi));
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      inc = !m_inh[0];
            else if (c == 1) inc = ret && !m_inh[2];
            else             inc = hpm[c-2] && !m_inh[c+1];
            if (c == wc) begin
                if (whi) m_cnt[c][63:32] = wd;
                else     m_cnt[c][31:0]  = wd;
            end else if (inc) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
        end
        if (m_presc == 3) begin
            m_presc = 0;
            m_time  = m_time + 1;
        end else begin
            m_presc++;
        end
        m_inh = inh_next;
    endfunction

    // One clock of dut_a traffic: drive at negedge, compare comb outputs, advance model at posedge.
    task automatic cyc(input logic [11:0] ra, input bit we, input logic [11:0] wa,
                       input logic [31:0] wd, input bit ret, input logic [3:0] hpm);
        logic [31:0] ed;
        logic        eh;
        int          wc;
        bit          whi;
        bit          legal;
        bus_a.rd_addr      = ra;
        bus_a.we           = we;
        bus_a.wr_addr      = wa;
        bus_a.wr_data      = wd;
        bus_a.instr_retire = ret;
        bus_a.hpm_event    = hpm;
        #1;
        model_read(ra, ed, eh);
        legal = wr_target(wa, wc, whi);
        check($sformatf("rd_data@%h", ra), 64'(bus_a.rd_data), 64'(ed));
        check($sformatf("rd_hit@%h", ra), 64'(bus_a.rd_hit), 64'(eh));
        check($sformatf("wr_illegal@%h", wa), 64'(bus_a.wr_illegal), 64'(we && !legal));
        last_ill = bus_a.wr_illegal;
        @(posedge clk);
        if (rst_a) model_reset();
        else       model_step(we, wa, wd, ret, hpm);
        @(negedge clk);
    endtask

    task automatic probe(input string tag, input logic [11:0] ra, input logic [31:0] exp);
        bus_a.rd_addr = ra;
        bus_a.we      = 1'b0;
        #1;
        check(tag, 64'(bus_a.rd_data), 64'(exp));
    endtask

    initial begin
        longint unsigned snap_c, snap_i, snap_h;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.rd_addr = '0; bus_a.we = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.instr_retire = 1'b0; bus_a.hpm_event = '0;
        bus_b.rd_addr = '0; bus_b.we = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.instr_retire = 1'b0; bus_b.hpm_event = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        probe("reset_cycle", 12'hC00, 32'h0);
        probe("reset_time", 12'hC01, 32'h0);
        probe("reset_inhibit", 12'h320, 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Asynchronous reset mid-count
        cyc(12'hC00, 1'b1, 12'hB00, 32'h0000_1234, 1'b0, 4'h0);
        probe("cycle_pre_reset", 12'hC00, 32'h0000_1234);
        rst_a = 1'b1;
        #1;
        check("reset_async", 64'(bus_a.rd_data), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) cyc(12'hC00, 1'b0, 12'h000, 32'h0, 1'b0, 4'h0);
        probe("cycle_after_5", 12'hC00, 32'd5);
        probe("cycleh_after_5", 12'hC80, 32'd0);

        // Prescaled time and read-only write
        repeat (7) cyc(12'hC01, 1'b0, 12'h000, 32'h0, 1'b0, 4'h0);
        probe("time_after_12", 12'hC01, 32'd3);
        cyc(12'hC01, 1'b1, 12'hC01, 32'hDEAD_BEEF, 1'b0, 4'h0);
        check("illegal_time_write", 64'(last_ill), 64'h1);
        probe("time_unchanged", 12'hC01, 32'd3);

        // Low-half carry into high half
        cyc(12'hC00, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 4'h0);
        cyc(12'hC00, 1'b0, 12'h000, 32'h0, 1'b0, 4'h0);
        cyc(12'hC80, 1'b0, 12'h000, 32'h0, 1'b0, 4'h0);
        probe("wrap_lo", 12'hC00, 32'd1);
        probe("wrap_hi", 12'hC80, 32'd1);

        // Write beats a concurrent retire
        cyc(12'hB02, 1'b1, 12'hB02, 32'h10, 1'b1, 4'h0);
        probe("instret_written", 12'hB02, 32'h10);
        cyc(12'hC02, 1'b0, 12'h000, 32'h0, 1'b1, 4'h0);
        probe("instret_plus1", 12'hC02, 32'h11);

        // Inhibit cycle and instret, hpm3 keeps counting
        cyc(12'h320, 1'b1, 12'h320, 32'h5, 1'b0, 4'h0);
        probe("inhibit_rd", 12'h320, 32'h5);
        snap_c = m_cnt[0];
        snap_i = m_cnt[1];
        snap_h = m_cnt[2];
        repeat (8) cyc(12'hC03, 1'b0, 12'h000, 32'h0, 1'b1, 4'b0001);
        probe("cycle_frozen", 12'hC00, snap_c[31:0]);
        probe("instret_frozen", 12'hC02, snap_i[31:0]);
        probe("hpm3_counts", 12'hC03, 32'(snap_h + 8));
        cyc(12'h320, 1'b1, 12'h320, 32'h2, 1'b0, 4'h0);
        probe("inhibit_bit1_ro", 12'h320, 32'h0);

        // Full 64-bit wrap
        cyc(12'hC80, 1'b1, 12'hB80, 32'hFFFF_FFFF, 1'b0, 4'h0);
        cyc(12'hC00, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 4'h0);
        cyc(12'hC00, 1'b0, 12'h000, 32'h0, 1'b0, 4'h0);
        probe("wrap64_lo", 12'hC00, 32'h0);
        probe("wrap64_hi", 12'hC80, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [11:0] ra, wa;
            logic [31:0] wd;
            bit          we;
            int          sel;
            ra  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 23)];
            wa  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 23)];
            we  = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 3);
            wd  = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'hFFFF_FFFE : 32'($urandom);
            if (wa == 12'h320 && $urandom_range(0, 1) == 0) wd = 32'h0;
            cyc(ra, we, wa, wd, 1'($urandom_range(0, 1)), 4'($urandom));
        end

        // Reduced configuration: 2 hpm counters, 40-bit width
        bus_b.rd_addr = 12'hC05;
        #1;
        check("b_c05_data", 64'(bus_b.rd_data), 64'h0);
        check("b_c05_hit", 64'(bus_b.rd_hit), 64'h0);
        bus_b.rd_addr = 12'hC04;
        #1;
        check("b_c04_hit", 64'(bus_b.rd_hit), 64'h1);
        bus_b.we      = 1'b1;
        bus_b.wr_addr = 12'hB05;
        bus_b.wr_data = 32'h1;
        #1;
        check("b_b05_illegal", 64'(bus_b.wr_illegal), 64'h1);
        bus_b.wr_addr = 12'hB83;
        bus_b.wr_data = 32'hFFFF_FFFF;
        #1;
        check("b_b83_legal", 64'(bus_b.wr_illegal), 64'h0);
        @(posedge clk);
        @(negedge clk);
        bus_b.we      = 1'b0;
        bus_b.rd_addr = 12'hC83;
        #1;
        check("b_c83_truncated", 64'(bus_b.rd_data), 64'hFF);
        bus_b.we      = 1'b1;
        bus_b.wr_addr = 12'hB03;
        @(posedge clk);
        @(negedge clk);
        bus_b.we        = 1'b0;
        bus_b.hpm_event = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus_b.hpm_event = 2'b00;
        bus_b.rd_addr   = 12'hC03;
        #1;
        check("b_wrap40_lo", 64'(bus_b.rd_data), 64'h0);
        bus_b.rd_addr = 12'hC83;
        #1;
        check("b_wrap40_hi", 64'(bus_b.rd_data), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
